// File: rtl/trace_sched_pkg.sv
// Shared types for the trace event scheduler: pipeline stage names, source
// geometry and helpers that split a source index into stage and lane.
package trace_sched_pkg;

  typedef enum logic [2:0] {
    ALN    = 3'd0,
    DEC    = 3'd1,
    EX1    = 3'd2,
    EX2    = 3'd3,
    EX3    = 3'd4,
    COMMIT = 3'd5,
    WB     = 3'd6
  } stage_e;

  localparam int NUM_STAGES = 7;
  localparam int NUM_LANES  = 2;
  localparam int NUM_SRC    = NUM_STAGES * NUM_LANES;
  localparam int SRC_W      = $clog2(NUM_SRC);

  typedef logic [SRC_W-1:0] src_idx_t;

  // Source index is 2*stage + lane, so the stage is the index without its LSB.
  function automatic stage_e src_stage(input src_idx_t s);
    return stage_e'(s[SRC_W-1:1]);
  endfunction

  // Lane is the LSB of the source index.
  function automatic logic src_lane(input src_idx_t s);
    return s[0];
  endfunction

endpackage

// File: rtl/trace_rr_arb.sv
// Round-robin pick: first requesting slot at or after ptr, wrapping modulo N.
module trace_rr_arb #(
  parameter int N = 14,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  // Scan N positions starting at ptr and latch onto the first request seen.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/trace_event_scheduler.sv
// Trace event scheduler: one pending slot per source, serialized onto a single
// valid/ready output by a round-robin arbiter, with a saturating drop counter.
module trace_event_scheduler
  import trace_sched_pkg::*;
#(
  parameter int NSRC = 14,
  parameter int PCW  = 32,
  parameter int CNTW = 16
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [NSRC-1:0]         src_valid,
  input  logic [NSRC*PCW-1:0]     src_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NSRC)-1:0] out_src,
  output logic [PCW-1:0]          out_pc,
  output logic [CNTW-1:0]         drop_cnt,
  output logic                    idle
);

  localparam int IW = $clog2(NSRC);
  localparam int PW = $clog2(NSRC + 1);
  localparam int SW = CNTW + PW;

  logic [NSRC-1:0] pend_reg, pend_next;
  logic [PCW-1:0]  slot_pc_reg [NSRC];
  logic [IW-1:0]   rr_ptr_reg;
  logic [NSRC-1:0] arb_grant, granted, fire, capture, drop;
  logic [IW-1:0]   arb_idx;
  logic            arb_any, load;
  logic [PW-1:0]   drop_num;
  logic [SW-1:0]   drop_sum;
  logic [CNTW-1:0] drop_cnt_next;

  // Output register may take a new event when empty or being consumed.
  assign load = !out_valid || out_ready;

  trace_rr_arb #(.N(NSRC)) u_arb (
    .req   (pend_reg),
    .ptr   (rr_ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Flush suppresses the grant so rr_ptr and the slots are not disturbed by it.
  assign granted = (load && !flush) ? arb_grant : '0;

  // A granted slot frees up this cycle, so a same-cycle event may refill it.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_slot
    assign fire[gi]    = src_valid[gi] && enable && !flush;
    assign capture[gi] = fire[gi] && (!pend_reg[gi] || granted[gi]);
    assign drop[gi]    = fire[gi] && pend_reg[gi] && !granted[gi];
  end

  // Next slot occupancy: flush clears, capture sets, grant empties.
  always_comb begin
    pend_next = pend_reg;
    for (int i = 0; i < NSRC; i++) begin
      if (flush)           pend_next[i] = 1'b0;
      else if (capture[i]) pend_next[i] = 1'b1;
      else if (granted[i]) pend_next[i] = 1'b0;
    end
  end

  // Slot flags are the only slot state needing reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) pend_reg <= '0;
    else        pend_reg <= pend_next;
  end

  // Slot PCs are only meaningful while the flag is set, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (capture[i]) slot_pc_reg[i] <= src_pc[i*PCW +: PCW];
    end
  end

  // Output register and round-robin pointer advance on each load.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid  <= 1'b0;
      out_src    <= '0;
      out_pc     <= '0;
      rr_ptr_reg <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= arb_any;
      if (arb_any) begin
        out_src    <= arb_idx;
        out_pc     <= slot_pc_reg[arb_idx];
        rr_ptr_reg <= (arb_idx == IW'(NSRC - 1)) ? '0 : arb_idx + IW'(1);
      end
    end
  end

  // Add this cycle's drop popcount, clamping at the all-ones value.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NSRC; i++) drop_num = drop_num + PW'(drop[i]);
    drop_sum = SW'(drop_cnt) + SW'(drop_num);
    if (drop_sum > SW'({CNTW{1'b1}})) drop_cnt_next = {CNTW{1'b1}};
    else                               drop_cnt_next = drop_sum[CNTW-1:0];
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) drop_cnt <= '0;
    else        drop_cnt <= drop_cnt_next;
  end

  assign idle = !(|pend_reg) && !out_valid;

endmodule

// File: doc/trace_event_scheduler.md
TRACE_EVENT_SCHEDULER -- requirements
Module: trace_event_scheduler

Interface
REQ-001 Parameter NSRC, default 14, number of trace sources; index = 2*stage + lane, lane 0/1.
REQ-002 Parameter PCW, default 32, PC width.
REQ-003 Parameter CNTW, default 16, drop-counter width.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_l  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  capture enable for new source events.
REQ-008 flush  in  1  synchronous clear of all buffered events.
REQ-009 src_valid  in  NSRC  per-source event strobe.
REQ-010 src_pc  in  NSRC*PCW  per-source PC; slice i belongs to source i.
REQ-011 out_valid  out  1  serialized event available.
REQ-012 out_ready  in  1  sink accepts the event.
REQ-013 out_src  out  $clog2(NSRC)  source index of the presented event.
REQ-014 out_pc  out  PCW  PC of the presented event.
REQ-015 drop_cnt  out  CNTW  saturating count of dropped events.
REQ-016 idle  out  1  no pending event and out_valid low.

Function
REQ-017 Each source SHALL own one pending slot (flag plus PC).
REQ-018 The slot SHALL capture when src_valid[i] && enable && !flush and the slot is empty or is granted this cycle.
REQ-019 An event arriving at an occupied, non-granted slot SHALL be dropped, keeping the old PC, and drop_cnt SHALL increment by 1.
REQ-020 drop_cnt SHALL saturate at 2^CNTW-1; multiple drops in one cycle SHALL add their popcount, clamped at saturation.
REQ-021 With enable low, new events SHALL be ignored and not counted; already-pending events SHALL keep draining.
REQ-022 The output register SHALL load when out_valid is low or out_valid && out_ready.
REQ-023 On load, a round-robin arbiter SHALL pick the first pending slot at or after rr_ptr, modulo NSRC.
REQ-024 On load, the scheduler SHALL copy that slot's index and PC to out_src/out_pc, clear the slot, and set rr_ptr = (grant+1) mod NSRC.
REQ-025 On load with no slot pending, out_valid SHALL go low.
REQ-026 While out_valid && !out_ready, out_valid/out_src/out_pc SHALL hold stable.
REQ-027 Latency: an event sampled at edge t into an idle scheduler SHALL show out_valid after edge t+1.
REQ-028 Throughput: the scheduler SHALL sustain one event per cycle while out_ready is high.
REQ-029 flush SHALL clear all slots and out_valid, leave rr_ptr and drop_cnt unchanged, and win over simultaneous capture and grant.
REQ-030 idle SHALL be combinational from the slot flags and out_valid.

Reset
REQ-031 rst_l low SHALL asynchronously clear all pending flags, out_valid, rr_ptr and drop_cnt to 0.
REQ-032 During reset, out_src and out_pc SHALL read 0 and idle SHALL read 1.
REQ-033 A reset mid-transfer SHALL discard the presented event with no handshake completion.

Structure
REQ-034 Package trace_sched_pkg SHALL define:
- stage enum: ALN=0, DEC, EX1, EX2, EX3, COMMIT, WB
- NUM_STAGES=7 and NUM_LANES=2
- the src index type and helper functions src->stage and src->lane.
REQ-035 The round-robin pick SHALL live in sub-module trace_rr_arb (req vector, ptr -> one-hot grant, index, any).
REQ-036 All remaining logic SHALL be implemented in the top module, with no other sub-modules.

Verification
REQ-037 Reset, then src_valid[3]=1 with pc 0x100 for one cycle, out_ready=1 -> out_valid high the cycle after capture with out_src=3, out_pc=0x100; idle=1 afterwards.
REQ-038 All 14 sources valid in one cycle (pc=0x1000+4*i), out_ready=1 -> 14 consecutive events in order 0..13, rr_ptr=0 afterwards, drop_cnt=0.
REQ-039 out_ready=0 with src 5 pending, then src 5 fires again twice -> out_src/out_pc stable; slot 5 was emptied into the output register, so the first re-fire captures and the second is dropped; drop_cnt=1.
REQ-040 Preload drop_cnt to 0xFFFE via repeated drops, then 3 more drops -> drop_cnt=0xFFFF and holds.
REQ-041 Sources 2 and 9 pending with out_valid high, then flush with src_valid[4] in the same cycle -> next cycle out_valid=0, idle=1, src 4 not captured, drop_cnt unchanged.
REQ-042 enable=0 with src_valid[0] pulsed while src 7 is pending -> src 7 is emitted, src 0 is never emitted, drop_cnt unchanged.
